// File: rtl/wbu_pkg.sv
// Shared definitions for the write-back stage: datapath width, reset PC,
// FSM state encoding and the next-PC source select encodings.
package wbu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  // Next-PC offset select (pcasrc) and base select (pcbsrc)
  localparam logic PCA_FOUR = 1'b0;
  localparam logic PCA_IMM  = 1'b1;
  localparam logic PCB_PC   = 1'b0;
  localparam logic PCB_SRC1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMMIT  = 2'd1,
    HANDOFF = 2'd2
  } wbu_state_e;

endpackage

// File: rtl/wbu_gpr_file.sv
// General-purpose register file: one synchronous write port, two
// asynchronous read ports, x0 and out-of-range indices read as zero.
module gpr_file #(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];

  function automatic logic in_range(input logic [4:0] a);
    return (a != '0) && (32'(a) < NREG);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && in_range(waddr)) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  assign rdata1 = in_range(raddr1) ? regs[raddr1[AW-1:0]] : '0;
  assign rdata2 = in_range(raddr2) ? regs[raddr2[AW-1:0]] : '0;

endmodule

// File: rtl/wbu.sv
// Write-back stage: captures a retired instruction, commits it to the GPR
// file, computes the next PC and hands it to fetch.
module wbu #(
  parameter int unsigned     XLEN     = wbu_pkg::XLEN,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = wbu_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exu_valid,
  output logic            wbu_ready,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      rd,
  input  logic            regwr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] src1,
  input  logic            pcasrc,
  input  logic            pcbsrc,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            wbu_valid,
  input  logic            ifu_ready,
  output logic [XLEN-1:0] next_pc
);

  import wbu_pkg::*;

  wbu_state_e      state;
  logic [XLEN-1:0] wd_q, pc_q, imm_q, src1_q;
  logic [4:0]      rd_q;
  logic            regwr_q, pcasrc_q, pcbsrc_q;
  logic [XLEN-1:0] npc_sum;
  logic            gpr_we;

  assign wbu_ready = (state == IDLE);
  assign wbu_valid = (state == HANDOFF);
  assign gpr_we    = (state == COMMIT) && regwr_q;

  always_comb begin
    npc_sum = ((pcbsrc_q == PCB_SRC1) ? src1_q : pc_q)
            + ((pcasrc_q == PCA_IMM)  ? imm_q  : XLEN'(4));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HANDOFF;
      next_pc  <= RESET_PC;
      wd_q     <= '0;
      rd_q     <= '0;
      regwr_q  <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      src1_q   <= '0;
      pcasrc_q <= 1'b0;
      pcbsrc_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (exu_valid) begin
            wd_q     <= wd;
            rd_q     <= rd;
            regwr_q  <= regwr;
            pc_q     <= pc;
            imm_q    <= imm;
            src1_q   <= src1;
            pcasrc_q <= pcasrc;
            pcbsrc_q <= pcbsrc;
            state    <= COMMIT;
          end
        end
        COMMIT: begin
          // bit 0 cleared for jalr; harmless for the aligned pc/branch cases
          next_pc <= {npc_sum[XLEN-1:1], 1'b0};
          state   <= HANDOFF;
        end
        HANDOFF: begin
          if (ifu_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  gpr_file #(
    .NREG (NREG),
    .XLEN (XLEN)
  ) u_gpr (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (gpr_we),
    .waddr  (rd_q),
    .wdata  (wd_q),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

endmodule

// File: tb/tb_wbu.sv
// Scoreboarded bench for wbu: an RV32I (NREG=32) and an RV32E (NREG=16)
// instance share all stimulus; next_pc transfers are checked by a monitor.
module tb_wbu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exu_valid, regwr, pcasrc, pcbsrc, ifu_ready;
  logic [31:0] wd, pc, imm, src1;
  logic [4:0]  rd, rs1, rs2;

  logic        wbu_ready, wbu_valid, wbu_ready16, wbu_valid16;
  logic [31:0] rdata1, rdata2, next_pc, rdata1_16, rdata2_16, next_pc16;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  wbu #(.XLEN(32), .NREG(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .exu_valid(exu_valid), .wbu_ready(wbu_ready),
    .wd(wd), .rd(rd), .regwr(regwr), .pc(pc), .imm(imm), .src1(src1),
    .pcasrc(pcasrc), .pcbsrc(pcbsrc), .rs1(rs1), .rs2(rs2),
    .rdata1(rdata1), .rdata2(rdata2), .wbu_valid(wbu_valid),
    .ifu_ready(ifu_ready), .next_pc(next_pc)
  );

  wbu #(.XLEN(32), .NREG(16), .RESET_PC(RST_PC)) dut16 (
    .clk(clk), .rst_n(rst_n), .exu_valid(exu_valid), .wbu_ready(wbu_ready16),
    .wd(wd), .rd(rd), .regwr(regwr), .pc(pc), .imm(imm), .src1(src1),
    .pcasrc(pcasrc), .pcbsrc(pcbsrc), .rs1(rs1), .rs2(rs2),
    .rdata1(rdata1_16), .rdata2(rdata2_16), .wbu_valid(wbu_valid16),
    .ifu_ready(ifu_ready), .next_pc(next_pc16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a fetch transfer takes place on the next rising edge
  always @(negedge clk) begin
    if (rst_n && wbu_valid && ifu_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL next_pc_unexpected: got %h, expected no transfer", next_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("next_pc", next_pc, e);
        check("next_pc_rv32e", next_pc16, e);
        check("valid_rv32e", {31'd0, wbu_valid16}, 32'd1);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20 && !wbu_ready; i++) begin
      @(posedge clk); #1;
    end
    check("wbu_ready_wait", {31'd0, wbu_ready}, 32'd1);
  endtask

  task automatic issue(input logic [31:0] i_wd, input logic [4:0] i_rd, input logic i_regwr,
                       input logic [31:0] i_pc, input logic [31:0] i_imm, input logic [31:0] i_src1,
                       input logic i_a, input logic i_b, input logic [31:0] i_exp, input logic push);
    wait_ready();
    wd = i_wd; rd = i_rd; regwr = i_regwr; pc = i_pc; imm = i_imm; src1 = i_src1;
    pcasrc = i_a; pcbsrc = i_b; exu_valid = 1'b1;
    if (push) exp_q.push_back(i_exp);
    @(posedge clk); #1;
    exu_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; ifu_ready = 1'b0; exu_valid = 1'b0;
    wd = '0; rd = '0; regwr = 1'b0; pc = '0; imm = '0; src1 = '0;
    pcasrc = 1'b0; pcbsrc = 1'b0; rs1 = 5'd5; rs2 = 5'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, wbu_valid}, 32'd1);
    check("rst_ready", {31'd0, wbu_ready}, 32'd0);
    check("rst_next_pc", next_pc, RST_PC);
    check("rst_gpr5", rdata1, 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, wbu_valid}, 32'd1);
      check("hold_next_pc", next_pc, RST_PC);
    end
    exp_q.push_back(RST_PC);
    ifu_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", {31'd0, wbu_ready}, 32'd1);
    check("idle_valid", {31'd0, wbu_valid}, 32'd0);

    // Plain write, sequential next PC
    issue(32'hDEAD_BEEF, 5'd5, 1'b1, 32'h8000_0010, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0014, 1'b1);
    rs1 = 5'd5; #1;
    check("no_bypass", rdata1, 32'd0);
    @(posedge clk); #1;
    check("gpr5", rdata1, 32'hDEAD_BEEF);
    check("gpr5_rv32e", rdata1_16, 32'hDEAD_BEEF);
    check("handoff_valid", {31'd0, wbu_valid}, 32'd1);

    // Write to x0 is dropped
    issue(32'h0000_1234, 5'd0, 1'b1, 32'h8000_0020, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0024, 1'b1);
    @(posedge clk); #1;
    rs1 = 5'd0; rs2 = 5'd5; #1;
    check("x0", rdata1, 32'd0);
    check("gpr5_kept", rdata2, 32'hDEAD_BEEF);

    // rd=20: valid on RV32I, dropped on RV32E (and must not alias x4)
    issue(32'h0000_55AA, 5'd20, 1'b1, 32'h8000_0030, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0034, 1'b1);
    @(posedge clk); #1;
    rs1 = 5'd20; rs2 = 5'd4; #1;
    check("gpr20", rdata1, 32'h0000_55AA);
    check("gpr4", rdata2, 32'd0);
    check("gpr20_rv32e", rdata1_16, 32'd0);
    check("gpr4_rv32e", rdata2_16, 32'd0);

    // jalr with link write
    issue(32'h8000_0044, 5'd1, 1'b1, 32'h8000_0040, 32'h10, 32'h8000_0101, 1'b1, 1'b1, 32'h8000_0110, 1'b1);
    @(posedge clk); #1;
    rs1 = 5'd1; #1;
    check("gpr1_link", rdata1, 32'h8000_0044);

    // Taken branch wrapping past 2^32, regwr=0
    issue(32'h0000_FFFF, 5'd6, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0000_0010, 1'b1);
    @(posedge clk); #1;
    rs1 = 5'd6; #1;
    check("gpr6_regwr0", rdata1, 32'd0);

    // src1+4 with odd base: bit 0 cleared
    issue(32'h0, 5'd0, 1'b0, 32'h8000_0050, 32'h0, 32'h1000_0003, 1'b0, 1'b1, 32'h1000_0006, 1'b1);

    // Back-pressure: second instruction waits for the fetch handshake
    wait_ready();
    ifu_ready = 1'b0;
    issue(32'h0000_AAAA, 5'd2, 1'b1, 32'h8000_0100, 32'h0, 32'h0, 1'b0, 1'b0, 32'h8000_0104, 1'b1);
    wd = 32'h0000_BBBB; rd = 5'd3; regwr = 1'b1; pc = 32'h8000_0200; imm = '0; src1 = '0;
    pcasrc = 1'b0; pcbsrc = 1'b0; exu_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd2;
    @(posedge clk); #1;
    repeat (5) begin
      check("bp_ready", {31'd0, wbu_ready}, 32'd0);
      check("bp_valid", {31'd0, wbu_valid}, 32'd1);
      check("bp_next_pc", next_pc, 32'h8000_0104);
      check("bp_gpr3", rdata1, 32'd0);
      @(posedge clk); #1;
    end
    check("bp_gpr2", rdata2, 32'h0000_AAAA);
    exp_q.push_back(32'h8000_0204);
    ifu_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", {31'd0, wbu_ready}, 32'd1);
    @(posedge clk); #1;
    exu_valid = 1'b0;
    check("bp_commit_ready", {31'd0, wbu_ready}, 32'd0);
    check("bp_gpr3_pending", rdata1, 32'd0);
    @(posedge clk); #1;
    check("bp_gpr3", rdata1, 32'h0000_BBBB);

    // Reset during COMMIT loses the pending write
    issue(32'h0000_7777, 5'd7, 1'b1, 32'h8000_0300, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    ifu_ready = 1'b0; rs1 = 5'd7; rs2 = 5'd5;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_next_pc", next_pc, RST_PC);
    check("mid_rst_valid", {31'd0, wbu_valid}, 32'd1);
    check("mid_rst_ready", {31'd0, wbu_ready}, 32'd0);
    check("mid_rst_gpr7", rdata1, 32'd0);
    check("mid_rst_gpr5", rdata2, 32'd0);
    @(posedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", {31'd0, wbu_valid}, 32'd1);
    check("post_rst_gpr7", rdata1, 32'd0);
    check("post_rst_next_pc", next_pc, RST_PC);
    exp_q.push_back(RST_PC);
    ifu_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {31'd0, wbu_ready}, 32'd1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
